// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer for the multicycle MIPS core.
// Owns the program counter, issues one instruction-memory request at a time
// and hands each fetched word plus its address to decode over valid/ready.
// Redirects from execute carry a ready-made target address.
// Build option DELAY_SLOT_EN: when defined, redirects follow MIPS branch-delay-
// slot semantics (nothing is flushed, the target is applied after the next
// delivery); when undefined, redirects flush immediately.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic [31:0] pc
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        issued_q, issued_d;
  logic [31:0] addr_q, addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_ins_q, if_ins_d;
  logic [31:0] if_pc_q, if_pc_d;
`ifdef DELAY_SLOT_EN
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
`else
  logic        stale_q, stale_d;
`endif

  logic        req_now;
  logic        ack_ok;
  logic [31:0] redir_pc;
  logic        unused_redir_lsbs;

  // Word-aligned redirect target; the low two target bits carry no meaning.
  assign redir_pc          = {redir_target[31:2], 2'b00};
  assign unused_redir_lsbs = ^redir_target[1:0];

  // Request decode: a request already on the bus is held until its ack, while a
  // fresh issue is suppressed by halt; reset drops the request immediately.
  always_comb begin
    req_now   = rst_n && (state_q == S_FETCH) && (issued_q || !halt);
    imem_req  = req_now;
    imem_addr = req_now ? (issued_q ? addr_q : pc_q) : 32'd0;
    ack_ok    = req_now && imem_ack;
  end

  // Next-state, PC and fetch-buffer logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issued_d   = issued_q;
    addr_d     = addr_q;
    if_valid_d = if_valid_q;
    if_ins_d   = if_ins_q;
    if_pc_d    = if_pc_q;
`ifdef DELAY_SLOT_EN
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
`else
    stale_d = stale_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (!req_now) begin
          // Halt seen before anything was issued: park without requesting.
          issued_d = 1'b0;
          state_d  = S_HALT;
`ifndef DELAY_SLOT_EN
          if (redir_valid) pc_d = redir_pc;
`endif
        end else if (ack_ok) begin
          issued_d = 1'b0;
`ifdef DELAY_SLOT_EN
          if_ins_d   = imem_rdata;
          if_pc_d    = imem_addr;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = S_HOLD;
`else
          if (stale_q || redir_valid) begin
            // Returning word belongs to the abandoned path: drop it and
            // re-issue from the (possibly just redirected) PC.
            stale_d = 1'b0;
            if (redir_valid) pc_d = redir_pc;
          end else begin
            if_ins_d   = imem_rdata;
            if_pc_d    = imem_addr;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = S_HOLD;
          end
`endif
        end else begin
          // Request outstanding: freeze its address until the ack.
          issued_d = 1'b1;
          addr_d   = imem_addr;
`ifndef DELAY_SLOT_EN
          if (redir_valid) begin
            stale_d = 1'b1;
            pc_d    = redir_pc;
          end
`endif
        end
      end

      S_HOLD: begin
`ifdef DELAY_SLOT_EN
        if (id_ready) begin
          if_valid_d = 1'b0;
          state_d    = halt ? S_HALT : S_FETCH;
          if (redir_valid)       pc_d = redir_pc;
          else if (pend_valid_q) pc_d = pend_target_q;
        end
`else
        if (redir_valid) begin
          if_valid_d = 1'b0;
          pc_d       = redir_pc;
          state_d    = S_FETCH;
        end else if (id_ready) begin
          if_valid_d = 1'b0;
          state_d    = halt ? S_HALT : S_FETCH;
        end
`endif
      end

      S_HALT: begin
`ifndef DELAY_SLOT_EN
        if (redir_valid) pc_d = redir_pc;
`endif
        if (!halt) state_d = S_FETCH;
      end

      default: begin
        state_d  = S_FETCH;
        issued_d = 1'b0;
      end
    endcase

`ifdef DELAY_SLOT_EN
    // The delivery of the delay slot consumes the pending target; otherwise
    // any redirect (re)loads it, last one winning.
    if ((state_q == S_HOLD) && id_ready) begin
      pend_valid_d = 1'b0;
    end else if (redir_valid) begin
      pend_valid_d  = 1'b1;
      pend_target_d = redir_pc;
    end
`endif
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= PC_INIT;
      issued_q   <= 1'b0;
      addr_q     <= 32'd0;
      if_valid_q <= 1'b0;
      if_ins_q   <= 32'd0;
      if_pc_q    <= 32'd0;
`ifdef DELAY_SLOT_EN
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
`else
      stale_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      if_valid_q <= if_valid_d;
      if_ins_q   <= if_ins_d;
      if_pc_q    <= if_pc_d;
`ifdef DELAY_SLOT_EN
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
`else
      stale_q <= stale_d;
`endif
    end
  end

  assign if_valid = if_valid_q;
  assign if_ins   = if_ins_q;
  assign if_pc    = if_pc_q;
  assign pc       = pc_q;

endmodule
